ps_reg_controller: RTL and testbench

PS_REG_CONTROLLER -- requirements
Module: ps_reg_controller

---
 rtl/ps_ctrl_pkg.sv | 12 +
 rtl/ps_shift_reg.sv | 27 ++
 rtl/ps_reg_controller.sv | 101 ++++++++++
 tb/tb_ps_reg_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps_ctrl_pkg.sv
// Shared types and defaults for the parallel/serial register controller.
package ps_ctrl_pkg;

  localparam int BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ps_state_t;

endpackage

// File: rtl/ps_shift_reg.sv
// Loadable shift register, MSB out / LSB in; load wins over shift, otherwise holds.
// Zero latency: q reflects load/shift on the same edge; no backpressure of its own.
module ps_shift_reg
  import ps_ctrl_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift,
  input  logic [BITS-1:0] d,
  input  logic            sin,
  output logic [BITS-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[BITS-2:0], sin};
    end
  end

endmodule

// File: rtl/ps_reg_controller.sv
// Serialises a parallel word MSB first while capturing ser_in; BITS shift cycles then a 1-cycle done.
// ser_ready low stalls the shift in place; start_valid is only honoured in IDLE without abort.
module ps_reg_controller
  import ps_ctrl_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [BITS-1:0] data_in,
  output logic            ser_out,
  output logic            ser_valid,
  input  logic            ser_ready,
  input  logic            ser_in,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] par_out
);

  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  ps_state_t       state;
  logic [CW-1:0]   count;
  logic            load;
  logic            shift;
  logic [BITS-1:0] q;

  // abort outranks both acceptance and a pending transfer
  assign start_ready = (state == IDLE) && !abort;
  assign load        = start_ready && start_valid;
  assign shift       = (state == SHIFT) && ser_ready && !abort;
  assign ser_out     = ser_valid & q[BITS-1];
  assign par_out     = q;

  ps_shift_reg #(
    .BITS(BITS)
  ) u_reg (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .shift(shift),
    .d    (data_in),
    .sin  (ser_in),
    .q    (q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state     <= SHIFT;
            count     <= '0;
            busy      <= 1'b1;
            ser_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            ser_valid <= 1'b0;
          end else if (ser_ready) begin
            if (count == LAST) begin
              state     <= DONE;
              count     <= '0;
              ser_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          busy      <= 1'b0;
          ser_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps_reg_controller.sv
// Directed bench for ps_reg_controller at BITS=4.
module tb_ps_reg_controller;

  localparam int BITS = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_valid;
  logic            start_ready;
  logic [BITS-1:0] data_in;
  logic            ser_out;
  logic            ser_valid;
  logic            ser_ready;
  logic            ser_in;
  logic            abort;
  logic            busy;
  logic            done;
  logic [BITS-1:0] par_out;

  int total = 0;
  int bad   = 0;

  logic [3:0] pat_out;
  logic [3:0] pat_in;
  int st_rdy [6] = '{1, 0, 0, 1, 1, 1};
  int st_sin [6] = '{1, 0, 0, 0, 0, 1};
  int st_out [6] = '{1, 0, 0, 0, 1, 1};

  ps_reg_controller #(.BITS(BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .data_in    (data_in),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_in     (ser_in),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .par_out    (par_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; data_in = '0;
    ser_ready = 1'b0; ser_in = 1'b0; abort = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_svld", ser_valid, 0);
    chk("rst_sout", ser_out, 0);
    chk("rst_par", par_out, 0);
    chk("rst_srdy", start_ready, 1);
    nxt(); nxt();
    reset = 1'b0;
    #1 chk("post_rst_par", par_out, 0);

    // basic job
    start_valid = 1'b1; data_in = 4'b1011; ser_ready = 1'b1;
    nxt();
    start_valid = 1'b0; data_in = '0;
    pat_out = 4'b1011; pat_in = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      ser_in = pat_in[3-i];
      #1;
      chk("basic_svld", ser_valid, 1);
      chk("basic_sout", ser_out, pat_out[3-i]);
      chk("basic_busy", busy, 1);
      chk("basic_nodone", done, 0);
      nxt();
    end
    #1;
    chk("basic_done", done, 1);
    chk("basic_par", par_out, 4'b1001);
    chk("basic_done_busy", busy, 1);
    chk("basic_done_svld", ser_valid, 0);
    chk("basic_done_srdy", start_ready, 0);
    nxt();
    chk("basic_idle_done", done, 0);
    chk("basic_idle_busy", busy, 0);
    chk("basic_idle_srdy", start_ready, 1);

    // stall for two cycles on the second bit
    start_valid = 1'b1; data_in = 4'b1011;
    nxt();
    start_valid = 1'b0; data_in = '0;
    for (int i = 0; i < 6; i++) begin
      ser_ready = st_rdy[i][0];
      ser_in    = st_sin[i][0];
      #1;
      chk("stall_sout", ser_out, st_out[i][0]);
      chk("stall_svld", ser_valid, 1);
      chk("stall_nodone", done, 0);
      if (i == 1 || i == 2) chk("stall_par", par_out, 4'b0111);
      nxt();
    end
    ser_ready = 1'b1;
    #1;
    chk("stall_done", done, 1);
    chk("stall_par_end", par_out, 4'b1001);
    nxt();

    // abort on SHIFT cycle 3
    start_valid = 1'b1; data_in = 4'b1011; ser_in = 1'b0;
    nxt();
    start_valid = 1'b0; data_in = '0;
    #1 chk("abort_c1", ser_out, 1);
    nxt();
    #1 chk("abort_c2", ser_out, 0);
    nxt();
    abort = 1'b1;
    #1;
    chk("abort_c3_sout", ser_out, 1);
    chk("abort_c3_srdy", start_ready, 0);
    nxt();
    abort = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_srdy", start_ready, 1);
    chk("abort_svld", ser_valid, 0);
    chk("abort_par", par_out, 4'hC);
    nxt();
    chk("abort_nodone_late", done, 0);

    // abort while idle blocks acceptance
    abort = 1'b1; start_valid = 1'b1; data_in = 4'h5;
    #1 chk("idle_abort_srdy", start_ready, 0);
    nxt();
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_par", par_out, 4'hC);
    abort = 1'b0; data_in = 4'h6;
    nxt();

    // follow-up job with an ignored request mid-shift
    start_valid = 1'b0; data_in = '0;
    pat_out = 4'b0110; pat_in = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      ser_in = pat_in[3-i];
      start_valid = (i == 1);
      data_in = (i == 1) ? 4'hF : 4'h0;
      #1;
      chk("post_abort_sout", ser_out, pat_out[3-i]);
      chk("post_abort_nodone", done, 0);
      nxt();
    end
    start_valid = 1'b0; data_in = '0;
    #1;
    chk("post_abort_done", done, 1);
    chk("post_abort_par", par_out, 4'h5);
    nxt();

    // reset in the middle of a job
    start_valid = 1'b1; data_in = 4'b1011; ser_in = 1'b0;
    nxt();
    start_valid = 1'b0; data_in = '0;
    nxt();
    #1 chk("midrst_c2_sout", ser_out, 0);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_svld", ser_valid, 0);
    chk("midrst_sout", ser_out, 0);
    chk("midrst_par", par_out, 0);
    chk("midrst_done", done, 0);
    chk("midrst_srdy", start_ready, 1);
    nxt();
    reset = 1'b0;
    start_valid = 1'b1; data_in = 4'hA; ser_in = 1'b0;
    #1;
    chk("midrst_rel_busy", busy, 0);
    chk("midrst_rel_done", done, 0);
    nxt();

    // back-to-back: 4'hA accepted on the first edge after reset, then 4'h5
    chk("b2b_first_accept", busy, 1);
    pat_out = 4'hA;
    for (int i = 0; i < 4; i++) begin
      #1 chk("b2b_a_sout", ser_out, pat_out[3-i]);
      nxt();
    end
    data_in = 4'h5; ser_in = 1'b1;
    #1;
    chk("b2b_a_done", done, 1);
    chk("b2b_a_par", par_out, 4'h0);
    chk("b2b_a_done_srdy", start_ready, 0);
    nxt();
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_srdy", start_ready, 1);
    chk("b2b_idle_svld", ser_valid, 0);
    nxt();
    start_valid = 1'b0; data_in = '0;
    pat_out = 4'h5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("b2b_5_svld", ser_valid, 1);
      chk("b2b_5_sout", ser_out, pat_out[3-i]);
      nxt();
    end
    #1;
    chk("b2b_5_done", done, 1);
    chk("b2b_5_par", par_out, 4'hF);
    nxt();
    chk("b2b_end_busy", busy, 0);
    chk("b2b_end_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
